uvma_rvfi_reorder_buf: RTL and testbench
========================================

// Module: uvma_rvfi_reorder_buf
// PURPOSE
// - Re-sequencer directly upstream of the RVFI instruction interface.
// - Accepts retirement packets that may arrive out of program order, each tagged with rvfi_order.
// - Emits them strictly in ascending rvfi_order, at most one per cycle.
// - The emitted stream drives the rvfi_valid/rvfi_order/payload pins that the RVFI monitor samples.
// PARAMETERS
// - DEPTH       8    Reorder window in entries; power of 2, >= 2.
// - PAYLOAD_W   256  Width of the opaque packed RVFI payload (insn, pc, rd, mem fields).
// - START_ORDER 1    First expected rvfi_order after reset.
// PORTS
// - clk          in   1                  Clock.
// - reset_n      in   1                  Asynchronous, active-low reset.
// - in_valid     in   1                  Retirement packet present this cycle; no backpressure.
// - in_order     in   ORDER_WL           rvfi_order tag of the incoming packet.
// - in_payload   in   PAYLOAD_W          Packed RVFI fields for the incoming packet.
// - flush        in   1                  Synchronous flush of all buffered entries.
// - flush_order  in   ORDER_WL           Next expected order after a flush.
// - out_valid    out  1                  Registered; drives rvfi_valid.
// - out_order    out  ORDER_WL           Registered; drives rvfi_order.
// - out_payload  out  PAYLOAD_W          Registered; payload of the emitted packet.
// - occupancy    out  $clog2(DEPTH+1)    Number of buffered entries.
// - err_stale    out  1                  1-cycle pulse: packet order is behind exp_order; packet dropped.
// - err_overflow out  1                  1-cycle pulse: packet order is outside the window; packet dropped.
// - err_dup      out  1                  1-cycle pulse: target slot already occupied; packet dropped.
// - err_sticky   out  1                  OR of all error pulses since reset or flush.
// BEHAVIOUR
// - Reset: all outputs 0, valid bits cleared, exp_order = START_ORDER.
// - Storage: slot index = order[IDX_W-1:0], where IDX_W = log2(DEPTH).
// - Classification of each in_valid packet:
//   - diff = in_order - exp_order, computed mod 2^ORDER_WL.
//   - diff[ORDER_WL-1] set -> err_stale.
//   - else diff >= DEPTH -> err_overflow.
//   - else slot occupied -> err_dup.
//   - else accepted.
//   - Dropped packets leave all state unchanged.
// - Emission (each cycle):
//   - If the head slot (exp_order) is valid: next cycle out_valid=1 with that entry; slot cleared; exp_order += 1.
//   - Else if an accepted input has diff==0: bypass to output next cycle without storing; exp_order += 1.
//   - Else out_valid=0. out_order and out_payload hold their last values.
// - Latency: an in-order packet appears on out_* exactly 1 cycle after in_valid.
// - Throughput: 1 packet/cycle sustained when input is in order.
// - Simultaneous write and drain:
//   - Accept a write to slot k while draining the head slot h in the same cycle.
//   - k==h with diff==0 cannot occur together with a valid head (that is err_dup).
//   - Occupancy updates by +1, -1, or 0 accordingly.
// - Wrap-around: exp_order and the tag arithmetic wrap modulo 2^ORDER_WL with no special case.
// - Full: occupancy==DEPTH is legal. A new packet then classifies as dup or overflow; it is never silently overwritten.
// - Flush:
//   - Clears all valid bits and err_sticky; sets exp_order = flush_order; next-cycle out_valid=0.
//   - in_valid in the flush cycle is ignored, with no error.
// - Reset mid-operation: async clear. Buffered entries are discarded and no output pulse occurs.
// STRUCTURE
// - uvma_rvfi_pkg holds ORDER_WL (reused from the RVFI agent).
// - uvma_rvfi_pkg also holds the new typedef uvma_rvfi_rob_err_e {NONE, STALE, OVERFLOW, DUP}.
// - Sub-module uvma_rvfi_rob_mem: DEPTH x PAYLOAD_W storage with 1 write port and 1 read port.
//   - Read is asynchronous, at the head index.
//   - Per-entry order register and valid bit live in the top level.
// TESTING
// - In-order stream, orders 1..20 back to back -> out_order 1..20 on consecutive cycles, each 1 cycle late, no errors.
// - Reversed input, orders 4,3,2,1 -> nothing emitted until 1 arrives; then 1,2,3,4 on 4 consecutive cycles; peak occupancy=3.
// - exp_order=1, in_order=9 with DEPTH=8 -> err_overflow pulse, occupancy unchanged. Then in_order=0 -> err_stale.
// - Same order 3 sent twice before 1,2 -> second copy gives err_dup, err_sticky=1; the first copy is emitted after 2.
// - Wrap: flush_order=2^ORDER_WL-2, then send max-1, 0, max -> emitted max-1, max, 0.
// - Fill 7 entries, assert reset_n=0 mid-stream -> all outputs 0; after release, order START_ORDER is emitted normally.

Source files
------------

// File: rtl/uvma_rvfi_pkg.sv
// Shared RVFI agent types and widths.
// Holds the reorder-buffer error classification.
package uvma_rvfi_pkg;

  localparam int ORDER_WL = 64;

  typedef enum logic [1:0] {
    NONE,
    STALE,
    OVERFLOW,
    DUP
  } uvma_rvfi_rob_err_e;

endpackage

// File: rtl/uvma_rvfi_rob_mem.sv
// Payload storage for the RVFI reorder buffer.
// One write port and one asynchronous read port.
module uvma_rvfi_rob_mem #(
  parameter int DEPTH     = 8,
  parameter int PAYLOAD_W = 256,
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [PAYLOAD_W-1:0] wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [PAYLOAD_W-1:0] rdata
);

  logic [PAYLOAD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uvma_rvfi_reorder_buf.sv
// Re-sequences out-of-order retirement packets
// into ascending rvfi_order, one per cycle.
module uvma_rvfi_reorder_buf
  import uvma_rvfi_pkg::*;
#(
  parameter int                  DEPTH       = 8,
  parameter int                  PAYLOAD_W   = 256,
  parameter logic [ORDER_WL-1:0] START_ORDER = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [ORDER_WL-1:0]        in_order,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic                       flush,
  input  logic [ORDER_WL-1:0]        flush_order,
  output logic                       out_valid,
  output logic [ORDER_WL-1:0]        out_order,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_stale,
  output logic                       err_overflow,
  output logic                       err_dup,
  output logic                       err_sticky
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     valid_q;
  logic [ORDER_WL-1:0]  order_q [DEPTH];
  logic [ORDER_WL-1:0]  exp_q;
  logic [ORDER_WL-1:0]  diff;
  logic [IDX_W-1:0]     widx;
  logic [IDX_W-1:0]     head;
  logic [PAYLOAD_W-1:0] rdata;
  uvma_rvfi_rob_err_e   err;
  logic                 acc;
  logic                 drain;
  logic                 bypass;
  logic                 wr;

  assign diff = in_order - exp_q;
  assign widx = in_order[IDX_W-1:0];
  assign head = exp_q[IDX_W-1:0];

  always_comb begin
    err = NONE;
    if (!in_valid || flush)            err = NONE;
    else if (diff[ORDER_WL-1])         err = STALE;
    else if (diff >= ORDER_WL'(DEPTH)) err = OVERFLOW;
    else if (valid_q[widx])            err = DUP;
  end

  // A head hit always wins; an in-order packet only bypasses an empty head.
  assign acc    = in_valid && !flush && (err == NONE);
  assign drain  = !flush && valid_q[head];
  assign bypass = acc && !valid_q[head] && (diff == '0);
  assign wr     = acc && !bypass;

  uvma_rvfi_rob_mem #(
    .DEPTH    (DEPTH),
    .PAYLOAD_W(PAYLOAD_W),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr),
    .waddr(widx),
    .wdata(in_payload),
    .raddr(head),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      order_q      <= '{default: '0};
      exp_q        <= START_ORDER;
      out_valid    <= 1'b0;
      out_order    <= '0;
      out_payload  <= '0;
      occupancy    <= '0;
      err_stale    <= 1'b0;
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
      err_sticky   <= 1'b0;
    end else if (flush) begin
      valid_q      <= '0;
      exp_q        <= flush_order;
      out_valid    <= 1'b0;
      occupancy    <= '0;
      err_stale    <= 1'b0;
      err_overflow <= 1'b0;
      err_dup      <= 1'b0;
      err_sticky   <= 1'b0;
    end else begin
      err_stale    <= (err == STALE);
      err_overflow <= (err == OVERFLOW);
      err_dup      <= (err == DUP);
      err_sticky   <= err_sticky || (err != NONE);
      out_valid    <= drain || bypass;
      if (drain) begin
        valid_q[head] <= 1'b0;
        out_order     <= order_q[head];
        out_payload   <= rdata;
      end else if (bypass) begin
        out_order     <= in_order;
        out_payload   <= in_payload;
      end
      if (wr) begin
        valid_q[widx] <= 1'b1;
        order_q[widx] <= in_order;
      end
      if (drain || bypass) exp_q <= exp_q + 1'b1;
      occupancy <= occupancy + CNT_W'(wr) - CNT_W'(drain);
    end
  end

endmodule

// File: tb/tb_uvma_rvfi_reorder_buf.sv
// Bench for uvma_rvfi_reorder_buf: directed cases
// plus random traffic against an associative-array model.
module tb_uvma_rvfi_reorder_buf;
  import uvma_rvfi_pkg::*;

  localparam int DEPTH = 8;
  localparam int PW    = 256;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [ORDER_WL-1:0] START = 1;

  logic                clk = 0;
  logic                reset_n;
  logic                in_valid;
  logic [ORDER_WL-1:0] in_order;
  logic [PW-1:0]       in_payload;
  logic                flush;
  logic [ORDER_WL-1:0] flush_order;
  logic                out_valid;
  logic [ORDER_WL-1:0] out_order;
  logic [PW-1:0]       out_payload;
  logic [CW-1:0]       occupancy;
  logic                err_stale;
  logic                err_overflow;
  logic                err_dup;
  logic                err_sticky;

  uvma_rvfi_reorder_buf #(
    .DEPTH(DEPTH), .PAYLOAD_W(PW), .START_ORDER(START)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_order(in_order),
    .in_payload(in_payload), .flush(flush),
    .flush_order(flush_order), .out_valid(out_valid),
    .out_order(out_order), .out_payload(out_payload),
    .occupancy(occupancy), .err_stale(err_stale),
    .err_overflow(err_overflow), .err_dup(err_dup),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [PW-1:0]       m_buf [logic [ORDER_WL-1:0]];
  logic [ORDER_WL-1:0] m_exp;
  bit                  m_sticky;
  bit                  e_valid, e_st, e_ov, e_du;
  logic [ORDER_WL-1:0] e_order;
  logic [PW-1:0]       e_pl;
  int                  peak;

  task automatic chk(string tag, logic [PW-1:0] got, logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] p;
    for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic check_all();
    chk("out_valid", PW'(out_valid), PW'(e_valid));
    chk("out_order", PW'(out_order), PW'(e_order));
    chk("out_payload", out_payload, e_pl);
    chk("occupancy", PW'(occupancy), PW'(m_buf.size()));
    chk("err_stale", PW'(err_stale), PW'(e_st));
    chk("err_overflow", PW'(err_overflow), PW'(e_ov));
    chk("err_dup", PW'(err_dup), PW'(e_du));
    chk("err_sticky", PW'(err_sticky), PW'(m_sticky));
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_exp = START; m_sticky = 0;
    e_valid = 0; e_st = 0; e_ov = 0; e_du = 0;
    e_order = '0; e_pl = '0;
  endtask

  // One clock: drive, advance the model, then check after the edge.
  task automatic cyc(bit v, logic [ORDER_WL-1:0] ord,
                     bit fl = 0, logic [ORDER_WL-1:0] fo = '0);
    logic [ORDER_WL-1:0] d;
    logic [PW-1:0] pl;
    bit acc;
    pl = rnd_pl();
    in_valid = v; in_order = ord; in_payload = pl;
    flush = fl; flush_order = fo;
    e_st = 0; e_ov = 0; e_du = 0; acc = 0;
    if (fl) begin
      m_buf.delete(); m_exp = fo; m_sticky = 0; e_valid = 0;
    end else begin
      d = ord - m_exp;
      if (v) begin
        if (d[ORDER_WL-1])          e_st = 1;
        else if (d >= DEPTH)        e_ov = 1;
        else if (m_buf.exists(ord)) e_du = 1;
        else                        acc = 1;
      end
      e_valid = 0;
      if (m_buf.exists(m_exp)) begin
        e_valid = 1; e_order = m_exp; e_pl = m_buf[m_exp];
        m_buf.delete(m_exp); m_exp = m_exp + 1;
      end else if (acc && d == 0) begin
        e_valid = 1; e_order = ord; e_pl = pl;
        acc = 0; m_exp = m_exp + 1;
      end
      if (acc) m_buf[ord] = pl;
      m_sticky = m_sticky | e_st | e_ov | e_du;
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    check_all();
    if (int'(occupancy) > peak) peak = int'(occupancy);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, '0);
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  logic [ORDER_WL-1:0] mx;
  logic [ORDER_WL-1:0] ro;

  initial begin
    reset_n = 0; in_valid = 0; in_order = '0; in_payload = '0;
    flush = 0; flush_order = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    reset_n = 1;

    // in-order stream
    for (int i = 1; i <= 20; i++) cyc(1, ORDER_WL'(i));
    idle(2);

    // reversed 4,3,2,1
    cyc(0, '0, 1, ORDER_WL'(1));
    peak = 0;
    for (int i = 4; i >= 1; i--) cyc(1, ORDER_WL'(i));
    idle(5);
    chk("rev_peak", PW'(peak), PW'(3));

    // overflow then stale
    cyc(0, '0, 1, ORDER_WL'(1));
    cyc(1, ORDER_WL'(9));
    cyc(1, ORDER_WL'(0));
    idle(1);

    // duplicate 3
    cyc(0, '0, 1, ORDER_WL'(1));
    cyc(1, ORDER_WL'(3));
    cyc(1, ORDER_WL'(3));
    cyc(1, ORDER_WL'(1));
    cyc(1, ORDER_WL'(2));
    idle(3);

    // wrap
    mx = '1;
    cyc(0, '0, 1, mx - 1);
    cyc(1, mx - 1);
    cyc(1, '0);
    cyc(1, mx);
    idle(3);

    // full window then overflow/dup attempts
    cyc(0, '0, 1, ORDER_WL'(1));
    for (int i = 2; i <= 8; i++) cyc(1, ORDER_WL'(i));
    cyc(1, ORDER_WL'(9));
    cyc(1, ORDER_WL'(5));
    // flush with input present is ignored
    cyc(1, ORDER_WL'(1), 1, ORDER_WL'(1));

    // reset mid-stream with 7 buffered entries
    for (int i = 2; i <= 8; i++) cyc(1, ORDER_WL'(i));
    do_reset();
    cyc(1, START);
    idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        ro = ($urandom_range(0, 1) == 1) ? mx - ORDER_WL'($urandom_range(0, 5))
                                          : ORDER_WL'($urandom);
        cyc($urandom_range(0, 1) == 1, m_exp, 1, ro);
      end else if ($urandom_range(0, 3) == 0) begin
        cyc(0, '0);
      end else begin
        ro = m_exp + ORDER_WL'($urandom_range(0, 10)) - ORDER_WL'(2);
        cyc(1, ro);
      end
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
